// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU execution controller: state codes, counter width
// and the print-syscall code used to qualify pause requests.
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'b00,
    ST_HALT = 2'b01,
    ST_BRK  = 2'b10
  } state_e;

  localparam int          HALT_CNT_W      = 32;
  localparam logic [31:0] PRINT_SYSCALL_V0 = 32'd34;

  // Print syscalls keep running; every other syscall pauses the core.
  function automatic logic is_pause_syscall(input logic syscall, input logic [31:0] v0);
    return syscall && (v0 != PRINT_SYSCALL_V0);
  endfunction

endpackage

// File: rtl/go_debounce.sv
// Resume-button conditioner: two-flop synchronizer, DEB_CYCLES stable-sample
// debouncer and a registered one-cycle pulse on each accepted 0->1 transition.
module go_debounce #(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise
);

  localparam int              CNT_W    = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_dly_q, rise_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      rise_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
      // Any sample matching the current level restarts the stability count.
      if (sync2_q != level_q) begin
        if (cnt_q == CNT_LAST) begin
          level_q <= sync2_q;
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else begin
        cnt_q <= '0;
      end
      level_dly_q <= level_q;
      rise_q      <= level_q & ~level_dly_q;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;

endmodule

// File: rtl/run_ctrl.sv
// Execution controller: derives the PC/regfile enable from syscall pause, resume
// button and optional PC breakpoint (enabled by RUN_CTRL_BREAKPOINT_EN).
module run_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = 16,
  parameter int PC_W       = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  go,
  input  logic                  step,
  input  logic                  pause_req,
  input  logic [PC_W-1:0]       pc,
  input  logic [PC_W-1:0]       bp_addr,
  input  logic                  bp_en,
  output logic                  run,
  output logic [1:0]            state,
  output logic [HALT_CNT_W-1:0] halt_cnt
);

  state_e                  state_q;
  logic [HALT_CNT_W-1:0]   halt_cnt_q, halt_cnt_d;
  logic                    go_level, go_pulse;
  logic                    bp_hit;
  logic                    run_c;
  logic                    unused_ok;

  go_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_go_debounce (
    .clk  (clk),
    .rst  (rst),
    .din  (go),
    .level(go_level),
    .rise (go_pulse)
  );

`ifdef RUN_CTRL_BREAKPOINT_EN
  assign bp_hit    = bp_en && (pc == bp_addr);
  assign unused_ok = go_level;
`else
  assign bp_hit    = 1'b0;
  assign unused_ok = ^{go_level, bp_en, bp_addr, pc};
`endif

  // A resume grant ignores pause/breakpoint so the stalled instruction commits.
  always_comb begin
    run_c = 1'b0;
    if (rst) begin
      case (state_q)
        ST_RUN:  run_c = ~pause_req & ~bp_hit;
        default: run_c = go_pulse;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_RUN;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (pause_req)   state_q <= ST_HALT;
          else if (bp_hit) state_q <= ST_BRK;
          else if (step)   state_q <= ST_HALT;
        end
`ifdef RUN_CTRL_BREAKPOINT_EN
        ST_HALT, ST_BRK: begin
`else
        ST_HALT: begin
`endif
          if (go_pulse) state_q <= step ? ST_HALT : ST_RUN;
        end
        default: state_q <= ST_HALT;
      endcase
    end
  end

  always_comb begin
    halt_cnt_d = halt_cnt_q;
    if (!run_c && (halt_cnt_q != {HALT_CNT_W{1'b1}})) halt_cnt_d = halt_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) halt_cnt_q <= '0;
    else      halt_cnt_q <= halt_cnt_d;
  end

  assign run      = run_c;
  assign state    = state_q;
  assign halt_cnt = halt_cnt_q;

endmodule

// File: tb/tb_run_ctrl.sv
// Directed bench for run_ctrl with DEB_CYCLES=4 and a behavioural PC register.
module tb_run_ctrl;

  logic        clk = 1'b0;
  logic        rst, go, step, pause_req, bp_en, run;
  logic [31:0] pc, bp_addr, halt_cnt;
  logic [1:0]  state;
  logic        ld, pause_armed;
  logic [31:0] ld_val, pause_pc;
  int          checks = 0;
  int          errors = 0;

  run_ctrl #(.DEB_CYCLES(4), .PC_W(32)) dut (
    .clk(clk), .rst(rst), .go(go), .step(step), .pause_req(pause_req),
    .pc(pc), .bp_addr(bp_addr), .bp_en(bp_en),
    .run(run), .state(state), .halt_cnt(halt_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst) begin
    if (!rst)     pc <= 32'h0;
    else if (ld)  pc <= ld_val;
    else if (run) pc <= pc + 32'd4;
  end

  assign pause_req = pause_armed && (pc == pause_pc);

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic release_go();
    go = 1'b0;
    repeat (10) tick();
  endtask

  task automatic test_reset();
    rst = 1'b0; go = 0; step = 0; bp_en = 0; bp_addr = 0;
    ld = 0; ld_val = 0; pause_armed = 0; pause_pc = 0;
    #2;
    checks++; if (run !== 1'b0) begin errors++; $display("FAIL rst_run got %0b want 0", run); end
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL rst_state got %b want 00", state); end
    checks++; if (halt_cnt !== 32'd0) begin errors++; $display("FAIL rst_cnt got %0d want 0", halt_cnt); end
    tick();
    rst = 1'b1;
    #1;
    checks++; if (run !== 1'b1) begin errors++; $display("FAIL rel_run got %0b want 1", run); end
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++; if (run !== 1'b1) begin errors++; $display("FAIL run_idle[%0d] got %0b want 1", i, run); end
      checks++; if (state !== 2'b00) begin errors++; $display("FAIL state_idle[%0d] got %b want 00", i, state); end
      checks++; if (halt_cnt !== 32'd0) begin errors++; $display("FAIL cnt_idle[%0d] got %0d want 0", i, halt_cnt); end
    end
  endtask

  task automatic test_pause();
    pause_pc = 32'h40; pause_armed = 1; ld_val = 32'h40; ld = 1;
    tick();
    ld = 0;
    checks++; if (pc !== 32'h40) begin errors++; $display("FAIL pause_pc got %h want 40", pc); end
    checks++; if (run !== 1'b0) begin errors++; $display("FAIL pause_run got %0b want 0", run); end
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL pause_state0 got %b want 00", state); end
    tick();
    checks++; if (state !== 2'b01) begin errors++; $display("FAIL pause_state1 got %b want 01", state); end
    checks++; if (halt_cnt !== 32'd1) begin errors++; $display("FAIL pause_cnt1 got %0d want 1", halt_cnt); end
    for (int i = 2; i <= 4; i++) begin
      tick();
      checks++; if (halt_cnt !== i) begin errors++; $display("FAIL pause_cnt got %0d want %0d", halt_cnt, i); end
    end
    go = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      checks++; if (run !== (k == 7)) begin errors++; $display("FAIL press_run[%0d] got %0b want %0b", k, run, k == 7); end
      checks++; if (halt_cnt !== 4 + k) begin errors++; $display("FAIL press_cnt[%0d] got %0d want %0d", k, halt_cnt, 4 + k); end
    end
    tick();
    checks++; if (pc !== 32'h44) begin errors++; $display("FAIL resume_pc got %h want 44", pc); end
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL resume_state got %b want 00", state); end
    checks++; if (run !== 1'b1) begin errors++; $display("FAIL resume_run got %0b want 1", run); end
    checks++; if (halt_cnt !== 32'd11) begin errors++; $display("FAIL resume_cnt got %0d want 11", halt_cnt); end
    release_go();
    pause_armed = 0;
    checks++; if (halt_cnt !== 32'd11) begin errors++; $display("FAIL run_cnt_hold got %0d want 11", halt_cnt); end
  endtask

  task automatic test_step();
    logic [31:0] cur;
    step = 1; ld_val = 32'h40; ld = 1;
    tick();
    ld = 0;
    checks++; if (state !== 2'b01) begin errors++; $display("FAIL step_enter got %b want 01", state); end
    checks++; if (run !== 1'b0) begin errors++; $display("FAIL step_run got %0b want 0", run); end
    cur = 32'h40;
    for (int p = 0; p < 2; p++) begin
      go = 1'b1;
      for (int k = 1; k <= 8; k++) begin
        tick();
        if (k < 8) begin
          checks++; if (pc !== cur) begin errors++; $display("FAIL step_pc_hold got %h want %h", pc, cur); end
          checks++; if (run !== (k == 7)) begin errors++; $display("FAIL step_run[%0d] got %0b want %0b", k, run, k == 7); end
        end
      end
      cur = cur + 32'd4;
      checks++; if (pc !== cur) begin errors++; $display("FAIL step_pc got %h want %h", pc, cur); end
      checks++; if (state !== 2'b01) begin errors++; $display("FAIL step_state got %b want 01", state); end
      checks++; if (run !== 1'b0) begin errors++; $display("FAIL step_after_run got %0b want 0", run); end
      release_go();
      checks++; if (pc !== cur) begin errors++; $display("FAIL step_release_pc got %h want %h", pc, cur); end
    end
  endtask

  task automatic test_bounce();
    int pulses = 0;
    for (int i = 0; i < 20; i++) begin
      go = ((i / 2) % 2 == 0);
      tick();
      if (run === 1'b1) pulses++;
    end
    go = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (run === 1'b1) pulses++;
    end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL bounce_pulses got %0d want 1", pulses); end
    checks++; if (pc !== 32'h4C) begin errors++; $display("FAIL bounce_pc got %h want 4c", pc); end
    checks++; if (state !== 2'b01) begin errors++; $display("FAIL bounce_state got %b want 01", state); end
    release_go();
    step = 0;
    go = 1'b1;
    repeat (8) tick();
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL unstep_state got %b want 00", state); end
    checks++; if (run !== 1'b1) begin errors++; $display("FAIL unstep_run got %0b want 1", run); end
    release_go();
  endtask

  task automatic test_breakpoint();
    bp_en = 1; bp_addr = 32'h10; pause_pc = 32'h10; pause_armed = 1; ld_val = 32'h10; ld = 1;
    tick();
    ld = 0;
    checks++; if (run !== 1'b0) begin errors++; $display("FAIL prio_run got %0b want 0", run); end
    tick();
    checks++; if (state !== 2'b01) begin errors++; $display("FAIL prio_state got %b want 01", state); end
    pause_armed = 0;
    go = 1'b1;
    repeat (8) tick();
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL prio_resume got %b want 00", state); end
    release_go();
    ld_val = 32'h10; ld = 1;
    tick();
    ld = 0;
`ifdef RUN_CTRL_BREAKPOINT_EN
    checks++; if (run !== 1'b0) begin errors++; $display("FAIL bp_run got %0b want 0", run); end
    tick();
    checks++; if (state !== 2'b10) begin errors++; $display("FAIL bp_state got %b want 10", state); end
    checks++; if (pc !== 32'h10) begin errors++; $display("FAIL bp_pc got %h want 10", pc); end
    go = 1'b1;
    repeat (8) tick();
    checks++; if (pc !== 32'h14) begin errors++; $display("FAIL bp_resume_pc got %h want 14", pc); end
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL bp_resume_state got %b want 00", state); end
`else
    checks++; if (run !== 1'b1) begin errors++; $display("FAIL nobp_run got %0b want 1", run); end
    tick();
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL nobp_state got %b want 00", state); end
    checks++; if (pc !== 32'h14) begin errors++; $display("FAIL nobp_pc got %h want 14", pc); end
`endif
    bp_en = 0;
    release_go();
  endtask

  task automatic test_reset_mid();
    rst = 1'b0;
    #1;
    checks++; if (halt_cnt !== 32'd0) begin errors++; $display("FAIL pre_cnt got %0d want 0", halt_cnt); end
    tick();
    rst = 1'b1;
    pause_pc = 32'h40; pause_armed = 1; ld_val = 32'h40; ld = 1;
    tick();
    ld = 0;
    for (int i = 0; i < 200; i++) begin
      if (halt_cnt == 32'd57) break;
      tick();
    end
    checks++; if (halt_cnt !== 32'd57) begin errors++; $display("FAIL mid_cnt57 got %0d want 57", halt_cnt); end
    checks++; if (state !== 2'b01) begin errors++; $display("FAIL mid_state got %b want 01", state); end
    go = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    #1;
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL mid_rst_state got %b want 00", state); end
    checks++; if (halt_cnt !== 32'd0) begin errors++; $display("FAIL mid_rst_cnt got %0d want 0", halt_cnt); end
    checks++; if (run !== 1'b0) begin errors++; $display("FAIL mid_rst_run got %0b want 0", run); end
    go = 1'b0; pause_armed = 0;
    tick();
    rst = 1'b1;
    #1;
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++; if (run !== 1'b1 || state !== 2'b00 || halt_cnt !== 32'd0) begin
        errors++; $display("FAIL post_rst[%0d] run %0b state %b cnt %0d want 1 00 0", i, run, state, halt_cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_pause();
    test_step();
    test_bounce();
    test_breakpoint();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/run_ctrl.md
# run_ctrl

Execution controller for the single-cycle MIPS core. It produces the PC/register-file enable `run` from three inputs: the syscall pause request, a debounced resume button and an optional PC breakpoint. It sits between the board inputs and the PC register, replacing the hard-wired `run = ~pause | go` term. It also supplies a state code and a halted-cycle count to the display mux.

## Interface
Parameters:
- `DEB_CYCLES`, default 16: number of consecutive stable samples needed to accept a new level on `go`.
- `PC_W`, default 32: width of the PC and breakpoint address.

Ports:
- `clk` in 1: CPU clock, the divided `clk_N` domain.
- `rst` in 1: reset, asynchronous, active-low.
- `go` in 1: raw resume push-button, asynchronous to `clk`.
- `step` in 1: single-step mode switch, treated as level.
- `pause_req` in 1: current instruction is a non-print syscall (`SysCall & v0 != 34`).
- `pc` in PC_W: current PC register value.
- `bp_addr` in PC_W: breakpoint address.
- `bp_en` in 1: breakpoint enable.
- `run` out 1: PC/regfile/counter enable. Combinational from state and inputs.
- `state` out 2: controller state code.
- `halt_cnt` out 32: number of cycles with `run==0`.

## Operation
State machine, encoded on `state`:
- `RUN` = 2'b00
- `HALT` = 2'b01
- `BRK` = 2'b10
- 2'b11 is illegal and recovers to `HALT`.

Internal signals:
- `bp_hit = bp_en & (pc == bp_addr)`.
- `go_pulse` is a single-cycle pulse on a debounced 0→1 transition of `go`.

`run` equation:
- In `RUN`: `run = ~pause_req & ~bp_hit`.
- In `HALT` or `BRK`: `run = go_pulse`. This grant ignores `pause_req` and `bp_hit`, so the instruction that caused the halt commits.

Transitions in `RUN`:
- `pause_req` → `HALT`. This has priority over `bp_hit`.
- Otherwise `bp_hit` → `BRK`.
- Otherwise, if `step==1`, go to `HALT` after the current instruction commits (`run` is 1 that cycle).
- Otherwise stay in `RUN`.
- `go_pulse` has no effect in this state.

Transitions in `HALT` or `BRK`:
- `go_pulse` with `step==0` → `RUN`.
- `go_pulse` with `step==1` → `HALT`.
- No pulse → stay in the current state.

`halt_cnt`:
- Increments on every cycle with `run==0`.
- Saturates at 32'hFFFF_FFFF.
- Never clears except on reset.

`step` is sampled only on cycles where `run==1`.

## Timing
- Reset (`rst==0`): `state=RUN`, `halt_cnt=0`, and `run` forced to 0 while reset is asserted. Debouncer level is 0 and its counter is 0.
- Reset asserted mid-operation: all state clears immediately. A pending `go_pulse` is lost.
- `run` has zero latency relative to `pause_req`/`bp_hit`. The PC does not advance on the cycle the syscall or breakpoint PC is presented.
- `go` path:
  - Two-flop synchronizer.
  - Then DEB_CYCLES identical samples update the debounced level.
  - `go_pulse` asserts one cycle after that.
  - Press-to-pulse latency is DEB_CYCLES+3 cycles.
  - Release must also be debounced before another pulse can occur.
- State updates on the rising `clk` edge after the deciding cycle. `state` is a registered output.

## Configuration
- `RUN_CTRL_BREAKPOINT_EN` defined: comparator and `BRK` state are present, as described above.
- Not defined:
  - `bp_hit` is tied to 0.
  - `bp_addr` and `bp_en` are unused.
  - `BRK` is unreachable, and illegal codes 2'b10/2'b11 recover to `HALT`.
  - All other behaviour is identical.

## Structure
- Package `cpu_ctrl_pkg` holds:
  - the state enum, with the `RUN`/`HALT`/`BRK` encodings;
  - the `HALT_CNT_W=32` constant;
  - the print-syscall code 34, so the top level can form `pause_req`.
- Sub-module `go_debounce` contains the synchronizer, the stable-sample counter and the rising-edge pulse generator. Its ports are `clk`, `rst`, `din`, `level`, `rise`.
- The top level has one FSM process, one combinational `run` block and the saturating counter.

## Test plan
Bench uses DEB_CYCLES=4.
- Reset release, `pause_req=0`, `step=0`: `run=1` from the first cycle, `state=00`, `halt_cnt` stays 0 for 20 cycles.
- `pause_req=1` at pc 0x40: `run=0` in the same cycle, `state=01` next cycle, `halt_cnt` increments each cycle. Clean `go` press: `run=1` for exactly one cycle 7 cycles after the press, then `state=00`.
- `step=1`: each clean `go` press advances pc by exactly one instruction (0x40→0x44→0x48). `state` returns to 01 after each.
- `go` bouncing 1/0 every 2 cycles for 20 cycles then stable high: exactly one `go_pulse`, no extra PC advance.
- With `RUN_CTRL_BREAKPOINT_EN`, `bp_en=1`, `bp_addr=0x10`, `pause_req` and `bp_hit` in the same cycle: `state=01`, not 10. With `bp_hit` alone: `state=10`, and a resume passes 0x10. Without the macro the same stimulus never stops.
- `rst` pulsed low while in `HALT` with `halt_cnt=57`: `state=00` and `halt_cnt=0` immediately; the partially debounced press is discarded.
